regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port between NUM_REQ writeback sources, for example the ALU result path and the load/mul-div return path.
- Each source presents a valid/ready write request. The block grants one source per cycle using round-robin order.
- The granted write is registered and driven onto the register file's write_reg/write_data/RegWrite inputs.
- The block sits between the execute/memory writeback sources and the register file.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/regfile_write_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default widths, the zero register and the
// write-request record used by writeback arbiters.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int MAX_REQ    = 4;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// after last_grant, wrapping around. Shared with the memory-port arbiter.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]                         req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] last_grant,
  output logic [N-1:0]                         grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    // k = 1 first so the previous winner is considered last
    for (int k = 1; k <= N; k++) begin
      idx = PTR_W'((int'(last_grant) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a
// registered write stage. Define REGFILE_ARB_BYPASS_EN for the forwarding port.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      rf_busy,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      collision
`ifdef REGFILE_ARB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]         byp_addr,
  output logic                      byp_hit,
  output logic [DATA_W-1:0]         byp_data
`endif
);

  localparam int               PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               coll_hit;

  logic               wr_en_p1;
  logic [ADDR_W-1:0]  wr_addr_p1;
  logic [DATA_W-1:0]  wr_data_p1;
  logic               coll_p1;

  function automatic logic [ADDR_W-1:0] addr_of(input int i);
    return req_addr[i*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] data_of(input int i);
    return req_data[i*DATA_W +: DATA_W];
  endfunction

  // Busy register file masks every request so no grant, and no pointer move, happens
  assign arb_req = rf_busy ? '0 : req_valid;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req        (arb_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = PTR_W'(i);
        sel_addr  = addr_of(i);
        sel_data  = data_of(i);
      end
    end
  end

  // Collision looks at raw valids, independent of rf_busy and the grant
  always_comb begin
    coll_hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = i + 1; j < NUM_REQ; j++) begin
        if (req_valid[i] && req_valid[j] &&
            (addr_of(i) == addr_of(j)) && (addr_of(i) != '0)) begin
          coll_hit = 1'b1;
        end
      end
    end
  end

  // ---- stage p0 -> p1: registered write and pointer update ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= PTR_RESET;
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      coll_p1    <= 1'b0;
    end else begin
      coll_p1  <= coll_hit;
      wr_en_p1 <= xfer && (sel_addr != '0);
      if (xfer) begin
        last_grant <= grant_idx;
        wr_addr_p1 <= sel_addr;
        wr_data_p1 <= sel_data;
      end
    end
  end

  assign wr_en     = wr_en_p1;
  assign wr_addr   = wr_addr_p1;
  assign wr_data   = wr_data_p1;
  assign collision = coll_p1;

`ifdef REGFILE_ARB_BYPASS_EN
  // The register file commits after the edge, so readers forward the landing write
  assign byp_hit  = wr_en_p1 && (wr_addr_p1 == byp_addr) && (byp_addr != '0);
  assign byp_data = wr_data_p1;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: stimulus pushes expected writes to
// a scoreboard queue, a negedge monitor pops and compares each wr_en pulse.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rf_busy;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            collision;
`ifdef REGFILE_ARB_BYPASS_EN
  logic [AW-1:0]   byp_addr = '0;
  logic            byp_hit;
  logic [DW-1:0]   byp_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  wr_req_t exp_q[$];

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_busy   (rf_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .collision (collision)
`ifdef REGFILE_ARB_BYPASS_EN
    ,
    .byp_addr  (byp_addr),
    .byp_hit   (byp_hit),
    .byp_data  (byp_data)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1
  task automatic drive(input string name, input logic [1:0] v,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic busy, input logic [1:0] exp_rdy,
                       input logic exp_coll, input bit mon = 1'b1);
    wr_req_t w;
    bit      pend;
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    rf_busy   = busy;
    #2;
    chk({name, ".ready"}, 64'(req_ready), 64'(exp_rdy));
    pend = 1'b0;
    w    = '0;
    if (exp_rdy[0] && a0 != 5'd0) begin
      pend = 1'b1; w.addr = a0; w.data = d0;
    end else if (exp_rdy[1] && a1 != 5'd0) begin
      pend = 1'b1; w.addr = a1; w.data = d1;
    end
    if (pend && mon) exp_q.push_back(w);
    @(posedge clk);
    #1;
    chk({name, ".collision"}, 64'(collision), 64'(exp_coll));
    if (!pend) chk({name, ".wr_en_idle"}, 64'(wr_en), 64'd0);
  endtask

  always @(negedge clk) begin : monitor
    wr_req_t e;
    if (!reset && wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("mon.wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("mon.wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rf_busy   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.wr_en", 64'(wr_en), 64'd0);
    chk("rst.wr_addr", 64'(wr_addr), 64'd0);
    chk("rst.wr_data", 64'(wr_data), 64'd0);
    chk("rst.collision", 64'(collision), 64'd0);
    chk("rst.ready", 64'(req_ready), 64'd0);
    reset = 1'b0;

    // single request, requester 0 wins first after reset
    drive("single0", 2'b01, 5'd3, 5'd0, 32'hABCDEF12, 32'h0, 1'b0, 2'b01, 1'b0);
    drive("single1", 2'b10, 5'd0, 5'd4, 32'h0, 32'h44444444, 1'b0, 2'b10, 1'b0);

    // both valid: strict alternation starting from requester 0
    for (int i = 0; i < 6; i++)
      drive($sformatf("alt%0d", i), 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222,
            1'b0, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);

    // write to r0 is accepted, suppressed, and still advances the pointer
    drive("zero", 2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b0, 2'b01, 1'b0);
    drive("after_zero", 2'b11, 5'd5, 5'd6, 32'h55555555, 32'h66666666, 1'b0, 2'b10, 1'b0);

    // rf_busy blocks grants; pointer (last=1) resumes at requester 0
    for (int i = 0; i < 3; i++)
      drive($sformatf("busy%0d", i), 2'b11, 5'd8, 5'd9, 32'h88888888, 32'h99999999,
            1'b1, 2'b00, 1'b0);
    drive("unbusy", 2'b11, 5'd8, 5'd9, 32'h88888888, 32'h99999999, 1'b0, 2'b01, 1'b0);

    // collision detection
    drive("coll", 2'b11, 5'd7, 5'd7, 32'h70707070, 32'h07070707, 1'b0, 2'b10, 1'b1);
    drive("coll_busy", 2'b11, 5'd7, 5'd7, 32'h70707070, 32'h07070707, 1'b1, 2'b00, 1'b1);
    drive("coll_one", 2'b01, 5'd7, 5'd7, 32'h70707070, 32'h07070707, 1'b0, 2'b01, 1'b0);
    drive("coll_zero", 2'b11, 5'd0, 5'd0, 32'h12345678, 32'h87654321, 1'b0, 2'b10, 1'b0);

    // async reset while a write is on the port
    drive("rst_pre", 2'b01, 5'd10, 5'd0, 32'h5A5A5A5A, 32'h0, 1'b0, 2'b01, 1'b0, 1'b0);
    chk("rst_pre.wr_en", 64'(wr_en), 64'd1);
    chk("rst_pre.wr_addr", 64'(wr_addr), 64'd10);
    chk("rst_pre.wr_data", 64'(wr_data), 64'h5A5A5A5A);
    req_valid = '0;
    reset     = 1'b1;
    #1;
    chk("async_rst.wr_en", 64'(wr_en), 64'd0);
    chk("async_rst.wr_addr", 64'(wr_addr), 64'd0);
    chk("async_rst.wr_data", 64'(wr_data), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive("post_rst", 2'b11, 5'd11, 5'd12, 32'hB0B0B0B0, 32'hC0C0C0C0, 1'b0, 2'b01, 1'b0);
    drive("flush", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
